// File: rtl/audio_src_sched.sv
// -----------------------------------------------------------------------------
// audio_src_sched
//
// Shares one I2S master transmitter between two stereo sample sources.
// Once per frame, during the right half of the word clock, it arbitrates
// between the sources and takes a single left/right pair over a valid/ready
// handshake. It commits that pair to stable output registers on the next
// right-to-left word-clock transition, which is where the transmitter loads its
// shift registers. If no pair arrives before that transition, it inserts silence
// or repeats the last pair, pulses `underrun`, and bumps a saturating counter.
//
// Parameters
//   HOLD_ON_UNDERRUN : 0 = output 0 on both channels after an underrun,
//                      1 = keep the previous pair.
//   CNT_W            : width of the saturating underrun counter.
//
// Ports
//   clk                        audio system clock (the transmitter's clock)
//   rst_n                      asynchronous reset, active low
//   audio_lrclk                word clock from the transmitter (0 = left, 1 = right)
//   src0_valid, src1_valid     source has a pair available
//   src0_ldata/rdata,
//   src1_ldata/rdata           sample pair offered by each source
//   src0_ready, src1_ready     pair accepted this cycle (combinational)
//   src_en[1:0]                per-source enable
//   prio_mode                  1 = src0 has fixed priority, 0 = round-robin
//   audio_ldata, audio_rdata   registered pair presented to the transmitter
//   active_src                 source of the pair now on audio_*data
//   underrun                   one-cycle pulse for a frame with no pair
//   underrun_cnt               saturating underrun count
// -----------------------------------------------------------------------------
module audio_src_sched #(
    parameter bit HOLD_ON_UNDERRUN = 1'b0,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_lrclk,
    input  logic             src0_valid,
    input  logic [15:0]      src0_ldata,
    input  logic [15:0]      src0_rdata,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [15:0]      src1_ldata,
    input  logic [15:0]      src1_rdata,
    output logic             src1_ready,
    input  logic [1:0]       src_en,
    input  logic             prio_mode,
    output logic [15:0]      audio_ldata,
    output logic [15:0]      audio_rdata,
    output logic             active_src,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HAVE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Word-clock synchronizer and edge register. All three reset to 1 so that
    // a word clock that is already high at reset release yields no false rise.
    logic        lr_meta;
    logic        lr_sync;
    logic        lr_prev;
    logic        rise;
    logic        fall;

    logic [1:0]  eligible;
    logic        win;          // 0 = src0, 1 = src1
    logic        take;         // handshake completes on this clock edge
    logic        last_grant;

    logic [15:0] stage_ldata;
    logic [15:0] stage_rdata;
    logic        stage_src;

    // -------------------------------------------------------------------------
    // Word clock synchronisation and edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_meta <= 1'b1;
            lr_sync <= 1'b1;
            lr_prev <= 1'b1;
        end else begin
            lr_meta <= audio_lrclk;
            lr_sync <= lr_meta;
            lr_prev <= lr_sync;
        end
    end

    assign rise = lr_sync & ~lr_prev;
    assign fall = ~lr_sync & lr_prev;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign eligible = src_en & {src1_valid, src0_valid};

    always_comb begin
        win = 1'b0;
        case (eligible)
            2'b10:   win = 1'b1;
            // Both eligible: fixed priority favours src0, round-robin favours
            // whichever source did not win last time.
            2'b11:   win = prio_mode ? 1'b0 : ~last_grant;
            default: win = 1'b0;
        endcase
    end

    // The frame boundary beats a pair that only becomes eligible in the same
    // cycle: that frame is already lost, so the pair waits for the next one
    // instead of being accepted and then stranded in staging.
    assign take       = (state == ARB) && !fall && (eligible != 2'b00);
    assign src0_ready = take & ~win;
    assign src1_ready = take &  win;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A fall seen here (first frame after reset) is ignored.
                if (rise) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (take) begin
                    state_next = HAVE;
                end
            end
            HAVE: begin
                // A stray rise here is ignored; only the frame boundary matters.
                if (fall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Staging, commit and underrun bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_ldata  <= '0;
            stage_rdata  <= '0;
            stage_src    <= 1'b0;
            last_grant   <= 1'b1;   // so that src0 wins the first round-robin tie
            audio_ldata  <= '0;
            audio_rdata  <= '0;
            active_src   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;

            if (take) begin
                stage_ldata <= win ? src1_ldata : src0_ldata;
                stage_rdata <= win ? src1_rdata : src0_rdata;
                stage_src   <= win;
                last_grant  <= win;
            end

            if (fall) begin
                if (state == HAVE) begin
                    audio_ldata <= stage_ldata;
                    audio_rdata <= stage_rdata;
                    active_src  <= stage_src;
                end else if (state == ARB) begin
                    underrun <= 1'b1;
                    if (underrun_cnt != {CNT_W{1'b1}}) begin
                        underrun_cnt <= underrun_cnt + CNT_W'(1);
                    end
                    // In hold mode, audio_*data and active_src are left as-is.
                    if (!HOLD_ON_UNDERRUN) begin
                        audio_ldata <= '0;
                        audio_rdata <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_src_sched.sv
// -----------------------------------------------------------------------------
// tb_audio_src_sched
//
// Drives two instances of audio_src_sched from the same stimulus:
//   dut_a : HOLD_ON_UNDERRUN=0, CNT_W=16
//   dut_b : HOLD_ON_UNDERRUN=1, CNT_W=2 (its counter saturates quickly)
// The word clock is generated as 128 clk high / 128 clk low. The reference
// model works per frame: each source presents a pair from a chosen offset
// and holds it until it is taken. The first cycle of the frame's arbitration
// window in which any enabled source is pending decides the winner. Expected
// grants and frame results are queued; separate monitors pop and compare them.
// -----------------------------------------------------------------------------
module tb_audio_src_sched;

    logic        clk;
    logic        rst_n;
    logic        lrclk;
    logic [1:0]  vld;
    logic [15:0] ld [2];
    logic [15:0] rd [2];
    logic [1:0]  src_en;
    logic        prio_mode;

    logic        r0a, r1a, act_a, und_a;
    logic [15:0] la, ra, cnt_a;
    logic        r0b, r1b, act_b, und_b;
    logic [15:0] lb, rb;
    logic [1:0]  cnt_b;

    audio_src_sched #(.HOLD_ON_UNDERRUN(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .audio_lrclk(lrclk),
        .src0_valid(vld[0]), .src0_ldata(ld[0]), .src0_rdata(rd[0]), .src0_ready(r0a),
        .src1_valid(vld[1]), .src1_ldata(ld[1]), .src1_rdata(rd[1]), .src1_ready(r1a),
        .src_en(src_en), .prio_mode(prio_mode),
        .audio_ldata(la), .audio_rdata(ra), .active_src(act_a),
        .underrun(und_a), .underrun_cnt(cnt_a)
    );

    audio_src_sched #(.HOLD_ON_UNDERRUN(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .audio_lrclk(lrclk),
        .src0_valid(vld[0]), .src0_ldata(ld[0]), .src0_rdata(rd[0]), .src0_ready(r0b),
        .src1_valid(vld[1]), .src1_ldata(ld[1]), .src1_rdata(rd[1]), .src1_ready(r1b),
        .src_en(src_en), .prio_mode(prio_mode),
        .audio_ldata(lb), .audio_rdata(rb), .active_src(act_b),
        .underrun(und_b), .underrun_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] la, ra, lb, rb;
        logic        act, und;
        logic [15:0] ca;
        logic [1:0]  cb;
    } commit_t;

    commit_t     cq[$];
    int          gq[$];
    int          checks   = 0;
    int          failures = 0;

    // reference model state
    bit          pending [2];
    bit          drop    [2];
    bit          last_grant;
    logic [15:0] stg_l, stg_r;
    bit          stg_src;
    logic [15:0] ea_l, ea_r, eb_l, eb_r;
    bit          e_act;
    logic [15:0] e_cnt_a;
    logic [1:0]  e_cnt_b;
    bit          rst_test;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_grant = 1'b1;
        ea_l = '0; ea_r = '0; eb_l = '0; eb_r = '0;
        e_act = 1'b0; e_cnt_a = '0; e_cnt_b = '0;
        drop[0] = 1'b0; drop[1] = 1'b0;
    endtask

    // Per-cycle source behaviour shared by every frame: retire a granted
    // pair, or start presenting a new one at the chosen offset.
    task automatic drive_sources(input int o, input int d0, input int d1);
        int d [2];
        d[0] = d0; d[1] = d1;
        for (int n = 0; n < 2; n++) begin
            if (drop[n]) begin
                vld[n]  = 1'b0;
                drop[n] = 1'b0;
            end
            if (!pending[n] && d[n] == o) begin
                pending[n] = 1'b1;
                ld[n]      = 16'($urandom);
                rd[n]      = 16'($urandom);
                vld[n]     = 1'b1;
            end
        end
    endtask

    // One frame, starting at the word clock rise. d0/d1: offset at which a
    // non-pending source starts presenting (-1 = not this frame).
    // nen/nprio take effect in the left half, ready for the next frame.
    task automatic frame(input int d0, input int d1, input logic [1:0] nen, input logic nprio);
        bit         granted;
        logic [1:0] el;
        int         w;
        commit_t    c;
        granted = 1'b0;
        for (int o = 0; o < 256; o++) begin
            @(posedge clk); #1;
            lrclk = (o < 128);
            drive_sources(o, d0, d1);
            if (o == 200) begin
                src_en    = nen;
                prio_mode = nprio;
            end
            // After 3 clk of edge detection, the window runs until the
            // synchronised fall is seen, 130 clk after the rise.
            if (!granted && o >= 3 && o <= 129) begin
                el = {pending[1], pending[0]} & src_en;
                if (el != 2'b00) begin
                    if (el == 2'b01)      w = 0;
                    else if (el == 2'b10) w = 1;
                    else if (prio_mode)   w = 0;
                    else                  w = last_grant ? 0 : 1;
                    gq.push_back(w);
                    granted    = 1'b1;
                    last_grant = (w == 1);
                    stg_l      = ld[w];
                    stg_r      = rd[w];
                    stg_src    = (w == 1);
                    pending[w] = 1'b0;
                    drop[w]    = 1'b1;
                end
            end
            if (o == 130) begin
                if (granted) begin
                    ea_l = stg_l; ea_r = stg_r; eb_l = stg_l; eb_r = stg_r;
                    e_act = stg_src;
                    c.und = 1'b0;
                end else begin
                    c.und = 1'b1;
                    if (e_cnt_a != 16'hFFFF) e_cnt_a = e_cnt_a + 16'd1;
                    if (e_cnt_b != 2'b11)    e_cnt_b = e_cnt_b + 2'd1;
                    ea_l = '0; ea_r = '0;
                end
                c.la = ea_l; c.ra = ea_r; c.lb = eb_l; c.rb = eb_r;
                c.act = e_act; c.ca = e_cnt_a; c.cb = e_cnt_b;
                cq.push_back(c);
            end
        end
    endtask

    function automatic int rand_offset();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)      return -1;
        else if (r < 6) return $urandom_range(0, 20);
        else if (r < 8) return $urandom_range(90, 135);
        else            return $urandom_range(136, 250);
    endfunction

    function automatic logic [1:0] rand_en();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0)      return 2'b00;
        else if (r < 3)  return 2'b01;
        else if (r < 5)  return 2'b10;
        else             return 2'b11;
    endfunction

    // Grant monitor: every ready pulse must match the next expected grant.
    int gw;
    always @(negedge clk) begin
        if (rst_n && !rst_test && (r0a | r1a | r0b | r1b)) begin
            chk("ready_both", {31'd0, r0a & r1a}, 32'd0);
            chk("ready_match_b", {30'd0, r0b, r1b}, {30'd0, r0a, r1a});
            if (gq.size() == 0) begin
                chk("ready_spurious", {30'd0, r0a, r1a}, 32'd0);
            end else begin
                gw = gq.pop_front();
                chk("grant_src", {30'd0, r0a, r1a}, (gw == 0) ? 32'd2 : 32'd1);
            end
        end
    end

    // Commit monitor: outputs are checked in the cycle after the commit edge,
    // i.e. 3 clk after the word clock fall reaches the edge detector.
    commit_t mc;
    initial begin
        forever begin
            @(negedge lrclk);
            repeat (3) @(negedge clk);
            chk("underrun_early", {30'd0, und_a, und_b}, 32'd0);
            @(negedge clk);
            if (cq.size() > 0) begin
                mc = cq.pop_front();
                chk("a_ldata",    la,    mc.la);
                chk("a_rdata",    ra,    mc.ra);
                chk("a_active",   act_a, mc.act);
                chk("a_underrun", und_a, mc.und);
                chk("a_cnt",      cnt_a, mc.ca);
                chk("b_ldata",    lb,    mc.lb);
                chk("b_rdata",    rb,    mc.rb);
                chk("b_active",   act_b, mc.act);
                chk("b_underrun", und_b, mc.und);
                chk("b_cnt",      cnt_b, mc.cb);
                $display("frame: a=%h/%h src=%0d und=%0d cnt_a=%0d | b=%h/%h cnt_b=%0d",
                         la, ra, act_a, und_a, cnt_a, lb, rb, cnt_b);
            end
            @(negedge clk);
            chk("underrun_width", {30'd0, und_a, und_b}, 32'd0);
        end
    end

    initial begin
        int  rst_o;
        bit  did_rst;
        rst_n = 1'b0; lrclk = 1'b0; vld = 2'b00;
        ld[0] = '0; ld[1] = '0; rd[0] = '0; rd[1] = '0;
        src_en = 2'b01; prio_mode = 1'b0; rst_test = 1'b0;
        pending[0] = 1'b0; pending[1] = 1'b0;
        model_reset();

        repeat (3) @(posedge clk); #1;
        chk("rst_ready",  {28'd0, r0a, r1a, r0b, r1b}, 32'd0);
        chk("rst_a_data", {la, ra}, 32'd0);
        chk("rst_b_data", {lb, rb}, 32'd0);
        chk("rst_misc",   {26'd0, act_a, und_a, act_b, und_b, cnt_b}, 32'd0);
        chk("rst_a_cnt",  cnt_a, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // single source
        frame(0, -1, 2'b01, 1'b0);
        frame(0, -1, 2'b11, 1'b0);
        // round-robin, both always valid
        frame(0, 0, 2'b11, 1'b0);
        frame(0, 0, 2'b11, 1'b0);
        frame(0, 0, 2'b11, 1'b1);
        // fixed priority, then src0 disabled
        frame(0, 0, 2'b11, 1'b1);
        frame(0, 0, 2'b10, 1'b1);
        frame(0, 0, 2'b00, 1'b0);
        // underruns (sources disabled), enough to saturate dut_b
        frame(0, 0, 2'b00, 1'b0);
        frame(-1, -1, 2'b00, 1'b0);
        frame(-1, -1, 2'b00, 1'b0);
        frame(-1, -1, 2'b01, 1'b0);
        // late valid inside the window, then after the fall
        frame(100, -1, 2'b01, 1'b0);
        frame(129, -1, 2'b01, 1'b0);
        frame(131, -1, 2'b01, 1'b0);
        frame(-1, -1, rand_en(), 1'($urandom));

        for (int i = 0; i < 40; i++) begin
            frame(rand_offset(), rand_offset(), (i == 39) ? 2'b01 : rand_en(), 1'($urandom));
        end

        // reset while src0 is being offered a grant
        rst_test = 1'b1;
        did_rst  = 1'b0;
        rst_o    = -100;
        for (int o = 0; o < 256; o++) begin
            @(posedge clk); #1;
            lrclk = (o < 128);
            drive_sources(o, 50, -1);
            if (o == 200) begin
                src_en    = 2'b11;
                prio_mode = 1'($urandom);
            end
            if (!rst_n && o == rst_o + 8) rst_n = 1'b1;
            @(negedge clk);
            if (!did_rst && rst_n && vld[0] && r0a) begin
                did_rst = 1'b1;
                rst_o   = o;
                rst_n   = 1'b0;
                #1;
                chk("midarb_ready", {28'd0, r0a, r1a, r0b, r1b}, 32'd0);
                chk("midarb_data",  {la, ra}, 32'd0);
                chk("midarb_bdata", {lb, rb}, 32'd0);
                chk("midarb_misc",  {26'd0, act_a, und_a, act_b, und_b, cnt_b}, 32'd0);
                chk("midarb_cnt",   cnt_a, 32'd0);
                $display("reset asserted mid-ARB at offset %0d", o);
                model_reset();
            end
        end
        chk("midarb_reset_hit", {31'd0, did_rst}, 32'd1);
        rst_test = 1'b0;

        for (int i = 0; i < 10; i++) begin
            frame(rand_offset(), rand_offset(), rand_en(), 1'($urandom));
        end

        repeat (300) @(posedge clk);
        chk("grant_queue_empty",  gq.size(), 32'd0);
        chk("commit_queue_empty", cq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_src_sched.md
# audio_src_sched

Sample scheduler that sits in front of the I2S master transmitter and shares it between two audio sample sources. Once per stereo frame it arbitrates between the sources and takes one left/right sample pair over a valid/ready handshake. It then presents that pair on stable 16-bit output registers that the transmitter captures at the frame boundary. If no source delivers a pair in time, it inserts silence or repeats the last sample and counts the underrun.

## Interface
Parameters:
- HOLD_ON_UNDERRUN, 0: on underrun, 0 outputs 16'h0000 on both channels; 1 holds the previous pair.
- CNT_W, 16: width of the saturating underrun counter.

Ports:
- clk  in  1  system audio clock (12.288 MHz, 256×48 kHz), same clock that drives the transmitter.
- rst_n  in  1  reset, asynchronous, active-low.
- audio_lrclk  in  1  word clock from the transmitter; 0 = left half, 1 = right half.
- src0_valid / src1_valid  in  1  source has a sample pair available.
- src0_ldata, src0_rdata / src1_ldata, src1_rdata  in  16  sample pair from each source (two's complement).
- src0_ready / src1_ready  out  1  pair accepted this cycle (combinational from state/grant).
- src_en  in  2  per-source enable; bit n gates source n.
- prio_mode  in  1  1 = fixed priority (src0 wins); 0 = round-robin.
- audio_ldata, audio_rdata  out  16  registered pair to the transmitter.
- active_src  out  1  source of the pair currently on audio_*data.
- underrun  out  1  one-cycle pulse when a frame had no sample.
- underrun_cnt  out  CNT_W  saturating underrun count.

## Operation
- audio_lrclk passes through a 2-flop synchronizer (reset value 1), then a 1-flop edge register (reset value 1).
  - rise = sync & ~prev.
  - fall = ~sync & prev.
- The transmitter loads its shift registers on the lrclk 1→0 edge. Outputs therefore change only after a detected fall, which keeps them stable for a full frame.
- FSM states: IDLE, ARB, HAVE.
  - IDLE: wait for rise → ARB.
  - ARB: eligible(n) = src_en[n] & srcn_valid.
    - If any source is eligible, assert ready to the winner only. Capture its pair into the staging regs and record the winner. Go to HAVE.
    - Fixed priority: src0 wins when both are eligible.
    - Round-robin: the source not granted last time wins. last_grant resets to 1, so src0 wins first.
    - Stay in ARB while no source is eligible.
    - If fall occurs in ARB: underrun. underrun=1 for one cycle, underrun_cnt+1 (saturates at all-ones). Outputs become zero or hold per HOLD_ON_UNDERRUN. Go to IDLE.
  - HAVE: on fall, commit the staging pair to audio_ldata/audio_rdata and set active_src. Go to IDLE.
- At most one handshake per frame. ready is never asserted outside ARB and never to both sources.
- Sources must hold valid and data stable until ready. A source that drops valid or src_en before the grant is simply not eligible; no transfer occurs.
- A fall in IDLE (first frame after reset) is ignored; outputs are unchanged.
- A rise while in HAVE is impossible in normal operation; if it occurs, it is ignored.
- prio_mode and src_en are sampled each ARB cycle.
- Reset (asynchronous, any time, including mid-ARB): state=IDLE; audio_ldata=audio_rdata=0; active_src=0; underrun=0; underrun_cnt=0; both ready=0; staging=0; last_grant=1.

## Timing
- Edge detection latency is 3 clk after an audio_lrclk transition (2 sync + 1 edge).
- ARB is entered 1 clk after rise is detected.
- The arbitration window is roughly 125 clk per frame at 48 kHz (a 128-clk right half minus sync latency).
- Handshake: transfer happens in the cycle where srcn_ready & srcn_valid are both high at the clk edge. The state is HAVE on the next cycle.
- Commit: audio_*data update on the clk edge where fall is seen in HAVE, and are visible the next cycle. They are then constant until the next fall.
- The underrun pulse and counter increment happen on the same edge as the missed commit.

## Test plan
- Single source: src_en=2'b01, src0 always valid with L=16'h1234 and R=16'hABCD. Expected: one src0_ready pulse per frame; audio_ldata=1234 and audio_rdata=ABCD after the first right-to-left transition; active_src=0; underrun_cnt stays 0.
- Round-robin: prio_mode=0, both sources always valid, src0=(0x1111,0x2222), src1=(0x3333,0x4444). Expected: committed pairs alternate src0, src1, src0, ...; grants are never simultaneous.
- Fixed priority: prio_mode=1, both sources valid. Expected: src0 is granted every frame and src1_ready stays 0. Then drop src_en[0]; from the next frame src1 is granted.
- Underrun: valid low for a whole right half. With HOLD_ON_UNDERRUN=0, outputs go to 0, underrun pulses once and the count goes 0→1. With HOLD_ON_UNDERRUN=1, the previous pair is held. Preset the counter near all-ones to check that it saturates.
- Late valid: src0_valid rises 100 clk into the right half. Expected: the pair is accepted and committed with no underrun. If valid rises after the lrclk fall instead, the frame underruns and the pair is accepted in the next frame.
- Reset mid-ARB: assert rst_n=0 while src0_valid=1 and the FSM is in ARB. Expected: ready drops immediately, all outputs return to reset values, and normal operation resumes after release.
